// File: rtl/load_store_unit.sv
// Byte-serial load/store initiator: splits B/H/W core requests into
// little-endian byte transfers and returns one response per request.
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWr,
  input  logic [2:0]  ReqCtrl,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RspValid,
  output logic [31:0] RspData,
  output logic        RspErr,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [7:0]  MemWData,
  input  logic [7:0]  MemRData,
  input  logic        MemAck
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e           state_q;
  logic             wr_q;
  logic [2:0]       ctrl_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    asm_q;
  logic [1:0]       k_q;
  logic [1:0]       last_q;
  logic [CNT_W-1:0] wait_q;

  logic             ready_q;
  logic             rsp_valid_q;
  logic [DW-1:0]    rsp_data_q;
  logic             rsp_err_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [AW-1:0]    mem_addr_q;
  logic [7:0]       mem_wdata_q;

  logic             req_err;
  logic [1:0]       req_last;
  logic [1:0]       k_nx;
  logic [DW-1:0]    asm_nx;
  logic [DW-1:0]    ld_data;

  // Request legality: illegal encodings, sign-less stores and misalignment
  always_comb begin
    req_err = 1'b0;
    case (ReqCtrl)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = ReqAddr[0];
      3'b010:  req_err = (ReqAddr[1:0] != 2'b00);
      3'b100:  req_err = ReqWr;
      3'b101:  req_err = ReqWr | ReqAddr[0];
      default: req_err = 1'b1;
    endcase
  end

  assign req_last = ReqCtrl[1] ? 2'd3 : (ReqCtrl[0] ? 2'd1 : 2'd0);
  assign k_nx     = k_q + 2'd1;

  // Assembly register with the byte arriving this cycle merged in
  always_comb begin
    asm_nx = asm_q;
    asm_nx[{k_q, 3'b000} +: 8] = MemRData;
  end

  // Sign/zero extension of the assembled load value
  always_comb begin
    ld_data = asm_nx;
    case (ctrl_q)
      3'b000:  ld_data = {{24{asm_nx[7]}}, asm_nx[7:0]};
      3'b100:  ld_data = {24'h0, asm_nx[7:0]};
      3'b001:  ld_data = {{16{asm_nx[15]}}, asm_nx[15:0]};
      3'b101:  ld_data = {16'h0, asm_nx[15:0]};
      default: ld_data = asm_nx;
    endcase
  end

  // Transaction FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      ctrl_q      <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      k_q         <= 2'd0;
      last_q      <= 2'd0;
      wait_q      <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ReqValid && ready_q) begin
            wr_q       <= ReqWr;
            ctrl_q     <= ReqCtrl;
            addr_q     <= ReqAddr;
            wdata_q    <= ReqWData;
            last_q     <= req_last;
            ready_q    <= 1'b0;
            rsp_data_q <= '0;
            if (req_err) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q     <= ACCESS;
              asm_q       <= '0;
              k_q         <= 2'd0;
              wait_q      <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= ReqWr;
              mem_addr_q  <= ReqAddr;
              mem_wdata_q <= ReqWData[7:0];
            end
          end
        end
        ACCESS: begin
          if (MemAck) begin
            wait_q <= '0;
            if (!wr_q) asm_q <= asm_nx;
            if (k_q != last_q) begin
              k_q         <= k_nx;
              mem_addr_q  <= addr_q + AW'(k_nx);
              mem_wdata_q <= wdata_q[{k_nx, 3'b000} +: 8];
            end else begin
              state_q     <= RESP;
              mem_req_q   <= 1'b0;
              mem_we_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_data_q  <= wr_q ? '0 : ld_data;
            end
          end else if ((ACK_TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
            state_q     <= RESP;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
          end else if (ACK_TIMEOUT != 0) begin
            wait_q <= wait_q + 1'b1;
          end
        end
        RESP: begin
          state_q    <= IDLE;
          ready_q    <= 1'b1;
          rsp_err_q  <= 1'b0;
          rsp_data_q <= '0;
        end
        default: begin
          state_q   <= IDLE;
          ready_q   <= 1'b1;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ReqReady = ready_q;
  assign RspValid = rsp_valid_q;
  assign RspData  = rsp_data_q;
  assign RspErr   = rsp_err_q;
  assign MemReq   = mem_req_q;
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus timeout and
// mid-transaction reset sequences against a byte memory responder.
module tb_load_store_unit;

  localparam int unsigned TO      = 4;
  localparam int          MAX_CYC = 60;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWr;
  logic [2:0]  ReqCtrl;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RspValid;
  logic [31:0] RspData;
  logic        RspErr;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [7:0]  MemWData;
  logic [7:0]  MemRData = 8'h00;
  logic        MemAck = 1'b0;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWr(ReqWr), .ReqCtrl(ReqCtrl),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RspValid(RspValid), .RspData(RspData), .RspErr(RspErr),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck)
  );

  always #5 clk = ~clk;

  // Byte memory: acks after ack_delay waiting cycles, logs every completed transfer
  logic [7:0]  mem [256];
  bit          mem_init = 1'b0;
  int          wcnt = 0;
  int          ack_delay = 0;
  bit          ack_en = 1'b1;
  logic [31:0] log_addr [$];
  logic [7:0]  log_data [$];

  always @(negedge clk) begin
    if (!mem_init) begin
      foreach (mem[i]) mem[i] = 8'h00;
      mem[8'h10] = 8'h34; mem[8'h11] = 8'hF2; mem[8'h12] = 8'h80; mem[8'h13] = 8'h7F;
      mem[8'h20] = 8'h01; mem[8'h21] = 8'h80;
      mem_init = 1'b1;
    end
    if (!MemReq) begin
      MemAck = 1'b0;
      wcnt   = 0;
    end else if (ack_en && wcnt == ack_delay) begin
      MemAck   = 1'b1;
      MemRData = mem[MemAddr[7:0]];
      if (MemWe) mem[MemAddr[7:0]] = MemWData;
      log_addr.push_back(MemAddr);
      log_data.push_back(MemWData);
      wcnt = 0;
    end else begin
      MemAck = 1'b0;
      wcnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request, watch it through to the response strobe
  task automatic run_req(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] data,
                         output logic err, output int reqcyc);
    logic        acked;
    logic        prev_req;
    logic [31:0] prev_addr;
    logic [7:0]  prev_wd;
    lat = -1; data = '0; err = 1'b0; reqcyc = 0;
    prev_req = 1'b0; prev_addr = '0; prev_wd = '0;
    @(negedge clk);
    chk("req_ready_before", 32'(ReqReady), 32'd1);
    ReqValid = 1'b1; ReqWr = wr; ReqCtrl = ctrl; ReqAddr = addr; ReqWData = wd;
    for (int c = 1; c <= MAX_CYC; c++) begin
      @(posedge clk);
      acked = MemAck;
      if (c == 1) begin
        #1;
        ReqValid = 1'b0;
      end
      @(negedge clk);
      if (MemReq) begin
        reqcyc++;
        if (prev_req && !acked) begin
          chk("hold_addr", MemAddr, prev_addr);
          chk("hold_wdata", 32'(MemWData), 32'(prev_wd));
        end
      end
      prev_req = MemReq; prev_addr = MemAddr; prev_wd = MemWData;
      if (RspValid) begin
        lat = c; data = RspData; err = RspErr;
        break;
      end
    end
    @(negedge clk);
    chk("rsp_one_cycle", 32'(RspValid), 32'd0);
    chk("ready_after_rsp", 32'(ReqReady), 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          nb;
  } vec_t;

  initial begin
    vec_t        vecs [$];
    vec_t        v;
    int          lat;
    int          reqcyc;
    int          base;
    int          exp_n;
    logic [31:0] data;
    logic        err;
    logic        seen;

    rst_n = 1'b0; ReqValid = 1'b0; ReqWr = 1'b0; ReqCtrl = 3'b000;
    ReqAddr = '0; ReqWData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",    32'(ReqReady), 32'd1);
    chk("rst_rspvalid", 32'(RspValid), 32'd0);
    chk("rst_rspdata",  RspData,       32'd0);
    chk("rst_rsperr",   32'(RspErr),   32'd0);
    chk("rst_memreq",   32'(MemReq),   32'd0);
    chk("rst_memwe",    32'(MemWe),    32'd0);
    chk("rst_memaddr",  MemAddr,       32'd0);
    chk("rst_memwdata", 32'(MemWData), 32'd0);
    rst_n = 1'b1;

    //                wr    ctrl    addr          wdata         dly exp_data      err   lat nb
    vecs.push_back('{1'b0, 3'b000, 32'h00000012, 32'h0,        0, 32'hFFFFFF80, 1'b0, 2,  1});
    vecs.push_back('{1'b0, 3'b100, 32'h00000012, 32'h0,        0, 32'h00000080, 1'b0, 2,  1});
    vecs.push_back('{1'b0, 3'b001, 32'h00000010, 32'h0,        0, 32'hFFFFF234, 1'b0, 3,  2});
    vecs.push_back('{1'b0, 3'b101, 32'h00000010, 32'h0,        0, 32'h0000F234, 1'b0, 3,  2});
    vecs.push_back('{1'b0, 3'b010, 32'h00000010, 32'h0,        0, 32'h7F80F234, 1'b0, 5,  4});
    vecs.push_back('{1'b0, 3'b010, 32'h00000021, 32'h0,        0, 32'h00000000, 1'b1, 1,  0});
    vecs.push_back('{1'b1, 3'b001, 32'h00000013, 32'h1234,     0, 32'h00000000, 1'b1, 1,  0});
    vecs.push_back('{1'b0, 3'b110, 32'h00000010, 32'h0,        0, 32'h00000000, 1'b1, 1,  0});
    vecs.push_back('{1'b1, 3'b100, 32'h00000010, 32'h55,       0, 32'h00000000, 1'b1, 1,  0});
    vecs.push_back('{1'b0, 3'b011, 32'h00000010, 32'h0,        0, 32'h00000000, 1'b1, 1,  0});
    vecs.push_back('{1'b0, 3'b001, 32'h00000011, 32'h0,        0, 32'h00000000, 1'b1, 1,  0});
    vecs.push_back('{1'b0, 3'b010, 32'h00000012, 32'h0,        0, 32'h00000000, 1'b1, 1,  0});
    vecs.push_back('{1'b1, 3'b010, 32'h00000010, 32'hA1B2C3D4, 0, 32'h00000000, 1'b0, 5,  4});
    vecs.push_back('{1'b0, 3'b010, 32'h00000010, 32'h0,        3, 32'hA1B2C3D4, 1'b0, 17, 4});
    vecs.push_back('{1'b1, 3'b000, 32'hFFFFFFFF, 32'hFFFF005A, 0, 32'h00000000, 1'b0, 2,  1});
    vecs.push_back('{1'b0, 3'b000, 32'hFFFFFFFF, 32'h0,        1, 32'h0000005A, 1'b0, 3,  1});
    vecs.push_back('{1'b0, 3'b101, 32'h00000020, 32'h0,        2, 32'h00008001, 1'b0, 7,  2});
    vecs.push_back('{1'b0, 3'b001, 32'h00000020, 32'h0,        0, 32'hFFFF8001, 1'b0, 3,  2});
    vecs.push_back('{1'b0, 3'b100, 32'h00000013, 32'h0,        0, 32'h000000A1, 1'b0, 2,  1});

    foreach (vecs[i]) begin
      v = vecs[i];
      ack_delay = v.dly;
      base = log_addr.size();
      run_req(v.wr, v.ctrl, v.addr, v.wdata, lat, data, err, reqcyc);
      exp_n = v.exp_err ? 0 : v.nb;
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d_data", i), data, v.exp_data);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(v.exp_err));
      chk($sformatf("v%0d_memreq_cycles", i), 32'(reqcyc), v.exp_err ? 32'd0 : 32'(v.exp_lat - 1));
      chk($sformatf("v%0d_transfers", i), 32'(log_addr.size() - base), 32'(exp_n));
      if (log_addr.size() == base + exp_n) begin
        for (int j = 0; j < exp_n; j++) begin
          chk($sformatf("v%0d_addr%0d", i, j), log_addr[base + j], v.addr + 32'(j));
          if (v.wr) chk($sformatf("v%0d_wbyte%0d", i, j), 32'(log_data[base + j]),
                        32'(v.wdata[8*j +: 8]));
        end
      end
    end

    // Ack never arrives: four waiting cycles then an error response
    ack_en = 1'b0;
    run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, data, err, reqcyc);
    chk("to_latency", 32'(lat), 32'd5);
    chk("to_memreq_cycles", 32'(reqcyc), 32'd4);
    chk("to_err", 32'(err), 32'd1);
    chk("to_data", data, 32'd0);
    ack_en = 1'b1;
    ack_delay = 0;
    run_req(1'b0, 3'b000, 32'h12, 32'h0, lat, data, err, reqcyc);
    chk("after_to_latency", 32'(lat), 32'd2);
    chk("after_to_data", data, 32'hFFFFFFB2);
    chk("after_to_err", 32'(err), 32'd0);

    // Reset while the second byte of a word store is on the bus
    @(negedge clk);
    chk("rr_ready", 32'(ReqReady), 32'd1);
    ReqValid = 1'b1; ReqWr = 1'b1; ReqCtrl = 3'b010; ReqAddr = 32'h40; ReqWData = 32'h11223344;
    @(posedge clk);
    #1;
    ReqValid = 1'b0;
    @(negedge clk);
    chk("rr_b0_req", 32'(MemReq), 32'd1);
    chk("rr_b0_addr", MemAddr, 32'h40);
    chk("rr_b0_wdata", 32'(MemWData), 32'h44);
    @(negedge clk);
    chk("rr_b1_req", 32'(MemReq), 32'd1);
    chk("rr_b1_addr", MemAddr, 32'h41);
    chk("rr_b1_wdata", 32'(MemWData), 32'h33);
    chk("rr_b1_we", 32'(MemWe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rr_async_memreq", 32'(MemReq), 32'd0);
    chk("rr_async_memwe", 32'(MemWe), 32'd0);
    chk("rr_async_ready", 32'(ReqReady), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (RspValid || MemReq) seen = 1'b1;
    end
    chk("rr_no_activity", 32'(seen), 32'd0);
    chk("rr_ready_after", 32'(ReqReady), 32'd1);
    chk("rr_memaddr", MemAddr, 32'd0);
    chk("rr_memwdata", 32'(MemWData), 32'd0);
    chk("rr_rspdata", RspData, 32'd0);
    chk("rr_rsperr", 32'(RspErr), 32'd0);
    run_req(1'b0, 3'b100, 32'h40, 32'h0, lat, data, err, reqcyc);
    chk("rr_reload_latency", 32'(lat), 32'd2);
    chk("rr_reload_data", data, 32'h00000044);
    chk("rr_reload_err", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
